// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two issue ports.
//
// Each cycle one valid request is granted and its operands are steered to
// the ALU. The ALU result and exception are captured into a single
// registered response stage that has valid/ready backpressure.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> requester 0 always wins contention
//                          undefined -> round-robin on the last accepted grant
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req0_valid/ready/a/b/op       issue port 0
//   req1_valid/ready/a/b/op       issue port 1
//   alu_a, alu_b, alu_op          operands/opcode to the ALU (zero when idle)
//   alu_res, alu_exc              result/overflow from the ALU
//   rsp_valid, rsp_ready          response handshake
//   rsp_id, rsp_res, rsp_exc      owner, result and exception of the response
module alu_arbiter #(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [31:0]    req0_a,
    input  logic [31:0]    req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [31:0]    req1_a,
    input  logic [31:0]    req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic [31:0]    alu_a,
    output logic [31:0]    alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [31:0]    alu_res,
    input  logic           alu_exc,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [31:0]    rsp_res,
    output logic           rsp_exc
);

    logic can_accept;
    logic grant0;
    logic grant1;
    logic accept0;
    logic accept1;

    // The response slot is free if empty or being drained this same cycle.
    assign can_accept = !rsp_valid || rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`else
    // Requester that was accepted most recently; loses the next contention.
    logic last_grant;

    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept0) begin
            last_grant <= 1'b0;
        end else if (accept1) begin
            last_grant <= 1'b1;
        end
    end
`endif

    assign req0_ready = can_accept && grant0;
    assign req1_ready = can_accept && grant1;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;

    // Operands follow the grant even while stalled; the ALU is combinational.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        if (grant0) begin
            alu_a  = req0_a;
            alu_b  = req0_b;
            alu_op = req0_op;
        end else if (grant1) begin
            alu_a  = req1_a;
            alu_b  = req1_b;
            alu_op = req1_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_res   <= '0;
            rsp_exc   <= 1'b0;
        end else if (accept0 || accept1) begin
            rsp_valid <= 1'b1;
            rsp_id    <= accept1;
            rsp_res   <= alu_res;
            rsp_exc   <= alu_exc;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed, table-driven bench for alu_arbiter with a
// small behavioural ALU stub (op0 add, op1 sub, op2 and, op3 or, op4 xor,
// op12 signed add with overflow, op13 signed sub with overflow).
module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_op;
    logic        alu_exc;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_exc;
    logic [31:0] rsp_res;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_exc(alu_exc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_exc(rsp_exc)
    );

    // ALU stub
    always_comb begin
        alu_res = '0;
        alu_exc = 1'b0;
        case (alu_op)
            4'd0:  alu_res = alu_a + alu_b;
            4'd1:  alu_res = alu_a - alu_b;
            4'd2:  alu_res = alu_a & alu_b;
            4'd3:  alu_res = alu_a | alu_b;
            4'd4:  alu_res = alu_a ^ alu_b;
            4'd12: begin
                alu_res = alu_a + alu_b;
                alu_exc = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            4'd13: begin
                alu_res = alu_a - alu_b;
                alu_exc = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            default: alu_res = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op0, input logic v1, input logic [31:0] a1,
                         input logic [31:0] b1, input logic [3:0] op1, input logic rr);
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp_ready  = rr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        v0;
        logic [31:0] a0, b0;
        logic [3:0]  op0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [3:0]  op1;
        logic        rr;
        logic        e_rdy0, e_rdy1;
        logic [31:0] e_aa, e_ab;
        logic [3:0]  e_op;
        logic        e_rv, e_id;
        logic [31:0] e_res;
        logic        e_exc;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic g;
        logic prev_id;
        logic [31:0] prev_res;

        vecs[0]  = '{"single",     1, 32'd5, 32'd7, 4'd0,  0, 0, 0, 4'd0, 1,
                     1, 0, 32'd5, 32'd7, 4'd0,  1, 0, 32'd12, 0};
        vecs[1]  = '{"ovf_add",    0, 0, 0, 4'd0,  1, 32'h7FFF_FFFF, 32'd1, 4'd12, 1,
                     0, 1, 32'h7FFF_FFFF, 32'd1, 4'd12,  1, 1, 32'h8000_0000, 1};
        vecs[2]  = '{"idle_stall", 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 0,
                     0, 0, 32'd0, 32'd0, 4'd0,  1, 1, 32'h8000_0000, 1};
        vecs[3]  = '{"bp1",        1, 32'd10, 32'd3, 4'd1,  0, 0, 0, 4'd0, 0,
                     0, 0, 32'd10, 32'd3, 4'd1,  1, 1, 32'h8000_0000, 1};
        vecs[4]  = '{"bp2",        1, 32'd10, 32'd3, 4'd1,  0, 0, 0, 4'd0, 0,
                     0, 0, 32'd10, 32'd3, 4'd1,  1, 1, 32'h8000_0000, 1};
        vecs[5]  = '{"bp3",        1, 32'd10, 32'd3, 4'd1,  0, 0, 0, 4'd0, 0,
                     0, 0, 32'd10, 32'd3, 4'd1,  1, 1, 32'h8000_0000, 1};
        vecs[6]  = '{"bp_release", 1, 32'd10, 32'd3, 4'd1,  0, 0, 0, 4'd0, 1,
                     1, 0, 32'd10, 32'd3, 4'd1,  1, 0, 32'd7, 0};
        vecs[7]  = '{"drain",      0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 1,
                     0, 0, 32'd0, 32'd0, 4'd0,  0, 0, 32'd7, 0};
        vecs[8]  = '{"empty_hold", 0, 0, 0, 4'd0,  0, 0, 0, 4'd0, 0,
                     0, 0, 32'd0, 32'd0, 4'd0,  0, 0, 32'd7, 0};
        vecs[9]  = '{"add_noovf",  1, 32'hFFFF_FFFF, 32'd1, 4'd12,  0, 0, 0, 4'd0, 0,
                     1, 0, 32'hFFFF_FFFF, 32'd1, 4'd12,  1, 0, 32'd0, 0};
        vecs[10] = '{"sub_ovf",    0, 0, 0, 4'd0,  1, 32'h8000_0000, 32'd1, 4'd13, 1,
                     0, 1, 32'h8000_0000, 32'd1, 4'd13,  1, 1, 32'h7FFF_FFFF, 1};
        vecs[11] = '{"contend",    1, 32'h0000_F0F0, 32'h0000_FF00, 4'd2,  1, 32'd1, 32'd2, 4'd3, 1,
                     1, 0, 32'h0000_F0F0, 32'h0000_FF00, 4'd2,  1, 0, 32'h0000_F000, 0};

        // Reset state
        rst_n = 1'b0;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        rsp_ready = 0;
        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id",    32'(rsp_id), 0);
        check("rst_rsp_res",   rsp_res, 0);
        check("rst_rsp_exc",   32'(rsp_exc), 0);
        check("rst_alu_op",    32'(alu_op), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table
        for (int unsigned i = 0; i < 12; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].op0,
                  vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].op1, vecs[i].rr);
            check({vecs[i].name, "_rdy0"},  32'(req0_ready), 32'(vecs[i].e_rdy0));
            check({vecs[i].name, "_rdy1"},  32'(req1_ready), 32'(vecs[i].e_rdy1));
            check({vecs[i].name, "_alu_a"}, alu_a, vecs[i].e_aa);
            check({vecs[i].name, "_alu_b"}, alu_b, vecs[i].e_ab);
            check({vecs[i].name, "_alu_op"}, 32'(alu_op), 32'(vecs[i].e_op));
            step();
            check({vecs[i].name, "_rsp_valid"}, 32'(rsp_valid), 32'(vecs[i].e_rv));
            check({vecs[i].name, "_rsp_id"},    32'(rsp_id), 32'(vecs[i].e_id));
            check({vecs[i].name, "_rsp_res"},   rsp_res, vecs[i].e_res);
            check({vecs[i].name, "_rsp_exc"},   32'(rsp_exc), 32'(vecs[i].e_exc));
        end

        // Reset mid-flight: response pending, no clock edge needed
        drive(0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 0);
        check("pre_rst_valid", 32'(rsp_valid), 1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(rsp_valid), 0);
        check("midrst_res",   rsp_res, 0);
        check("midrst_id",    32'(rsp_id), 0);
        #1 rst_n = 1'b1;

        // Round-robin from reset: 0,1,0,1 (fixed priority: 0,0,0,0)
        for (int unsigned i = 0; i < 4; i++) begin
            g = FIXED ? 1'b0 : i[0];
            drive(1, 32'd1, 32'd1, 4'd0, 1, 32'd100, 32'd1, 4'd0, 1);
            check($sformatf("rr%0d_rdy0", i), 32'(req0_ready), 32'(!g));
            check($sformatf("rr%0d_rdy1", i), 32'(req1_ready), 32'(g));
            check($sformatf("rr%0d_alu_a", i), alu_a, g ? 32'd100 : 32'd1);
            step();
            check($sformatf("rr%0d_rsp_id", i), 32'(rsp_id), 32'(g));
            check($sformatf("rr%0d_rsp_res", i), rsp_res, g ? 32'd101 : 32'd2);
        end
        prev_id  = FIXED ? 1'b0 : 1'b1;
        prev_res = FIXED ? 32'd2 : 32'd101;

        // Stall with only req0 valid: no accept, priority must not rotate
        drive(1, 32'd3, 32'd4, 4'd0, 0, 0, 0, 4'd0, 0);
        check("stall_rdy0", 32'(req0_ready), 0);
        check("stall_rdy1", 32'(req1_ready), 0);
        step();
        check("stall_valid", 32'(rsp_valid), 1);
        check("stall_id",    32'(rsp_id), 32'(prev_id));
        check("stall_res",   rsp_res, prev_res);

        // Idle drain
        drive(0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 1);
        check("idle_alu_a",  alu_a, 0);
        check("idle_alu_b",  alu_b, 0);
        check("idle_alu_op", 32'(alu_op), 0);
        check("idle_rdy0",   32'(req0_ready), 0);
        step();
        check("idle_drain_valid", 32'(rsp_valid), 0);
        check("idle_drain_res",   rsp_res, prev_res);
        check("idle_drain_id",    32'(rsp_id), 32'(prev_id));

        // Contention after drain: last grant unchanged, so req0 wins
        drive(1, 32'd3, 32'd4, 4'd0, 1, 32'd100, 32'd1, 4'd0, 0);
        check("post_rdy0", 32'(req0_ready), 1);
        check("post_rdy1", 32'(req1_ready), 0);
        step();
        check("post_id",  32'(rsp_id), 0);
        check("post_res", rsp_res, 32'd7);

        drive(0, 0, 0, 4'd0, 0, 0, 0, 4'd0, 1);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
